pipeline_sequencer: RTL and testbench

//   Sequences the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB) around decode/control outputs.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_sequencer.sv | 141 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and defaults for the ARM pipeline sequencer.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } seq_state_t;

    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear wins over increment, one-cycle update latency.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Per-stage enables/flushes for the 5-stage pipeline plus the SRAM access FSM.
// Control outputs are combinational (same cycle); a stalled SRAM access freezes every stage.
module pipeline_sequencer
    import arm_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             mem_start,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              run_rules;
    logic              stall_inc;

    always_comb begin
        next_state   = state;
        run_rules    = 1'b0;
        timeout      = 1'b0;
        mem_start    = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        exe_mem_en   = 1'b0;
        mem_wb_en    = 1'b0;

        case (state)
            RUN: begin
                if (mem_req) begin
                    mem_start  = 1'b1;
                    next_state = MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Release cycle: the held mem_req belongs to the instruction just served.
                if (mem_ready) begin
                    run_rules  = 1'b1;
                    next_state = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    next_state = ERROR;
                end
            end
            ERROR:   next_state = ERROR;
            default: next_state = RUN;
        endcase

        if (run_rules) begin
            if (branch_taken) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
                exe_mem_en   = 1'b1;
                mem_wb_en    = 1'b1;
            end else if (hazard) begin
                id_exe_flush = 1'b1;
                exe_mem_en   = 1'b1;
                mem_wb_en    = 1'b1;
            end else begin
                pc_en      = 1'b1;
                if_id_en   = 1'b1;
                exe_mem_en = 1'b1;
                mem_wb_en  = 1'b1;
            end
        end

        if (!rst_n) begin
            mem_start    = 1'b0;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_exe_flush = 1'b0;
            exe_mem_en   = 1'b0;
            mem_wb_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == MEM_WAIT) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    // ERROR also holds pc_en low but is not a stall the pipeline can recover from.
    assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: fixed vectors, corner sequences and random traffic against a model.
module tb_pipeline_sequencer;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 15;
    localparam int CMAX        = (1 << CNT_W) - 1;

    // {mem_start, pc_en, if_id_en, if_id_flush, id_exe_flush, exe_mem_en, mem_wb_en}
    localparam logic [6:0] ZERO  = 7'b0000000;
    localparam logic [6:0] RUNO  = 7'b0110011;
    localparam logic [6:0] HAZ   = 7'b0000111;
    localparam logic [6:0] BR    = 7'b0111111;
    localparam logic [6:0] START = 7'b1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hazard, branch_taken, mem_req, mem_ready, cnt_clr;
    logic mem_start, pc_en, if_id_en, if_id_flush, id_exe_flush, exe_mem_en, mem_wb_en, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;

    assign ctl = {mem_start, pc_en, if_id_en, if_id_flush, id_exe_flush, exe_mem_en, mem_wb_en};

    pipeline_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .cnt_clr      (cnt_clr),
        .mem_start    (mem_start),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_exe_flush (id_exe_flush),
        .exe_mem_en   (exe_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: is an SRAM access outstanding, how long has it waited, has it timed out.
    bit m_busy  = 1'b0;
    bit m_err   = 1'b0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        logic       r, h, b, q, y, c;
        logic [6:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] model_ctl(input logic r, h, b, q, y);
        if (!r || m_err)   return ZERO;
        if (!m_busy && q)  return START;
        if (m_busy && !y)  return ZERO;
        if (b)             return BR;
        if (h)             return HAZ;
        return RUNO;
    endfunction

    task automatic step(input logic r, h, b, q, y, c);
        logic [6:0] e;
        @(posedge clk);
        #1;
        rst_n = r; hazard = h; branch_taken = b; mem_req = q; mem_ready = y; cnt_clr = c;
        @(negedge clk);
        e = model_ctl(r, h, b, q, y);
        check("ctl", {25'd0, ctl}, {25'd0, e});
        check("stall_cnt", {24'd0, stall_cnt}, m_stall);
        check("flush_cnt", {24'd0, flush_cnt}, m_flush);
        check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        if (!r) begin
            m_busy = 0; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c) m_stall = 0;
            else if (!m_err && !e[5] && m_stall < CMAX) m_stall++;
            if (c) m_flush = 0;
            else if (e[3] && m_flush < CMAX) m_flush++;
            if (m_err) begin
            end else if (!m_busy && q) begin
                m_busy = 1; m_waits = 0;
            end else if (m_busy && !y) begin
                m_waits++;
                if (m_waits == MEM_TIMEOUT) begin
                    m_err = 1; m_busy = 0;
                end
            end else if (m_busy) begin
                m_busy = 0;
            end
        end
    endtask

    function automatic void add(input logic r, h, b, q, y, c, input logic [6:0] e, input int s, input int f);
        tbl.push_back('{r, h, b, q, y, c, e, s, f});
    endfunction

    initial begin
        rst_n = 0; hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
        @(posedge clk);
        @(posedge clk);

        //   r  h  b  q  y  c  ctl    stall flush
        add(0, 1, 0, 1, 0, 0, ZERO,  0, 0);
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, RUNO, 0, 0);
        add(1, 1, 0, 0, 0, 0, HAZ,   0, 0);
        add(1, 1, 0, 0, 0, 0, HAZ,   1, 0);
        add(1, 0, 0, 0, 0, 0, RUNO,  2, 0);
        add(1, 1, 1, 0, 0, 0, BR,    2, 0);
        add(1, 0, 0, 0, 0, 0, RUNO,  2, 1);
        add(1, 0, 0, 1, 0, 0, START, 2, 1);
        add(1, 0, 0, 1, 0, 0, ZERO,  3, 1);
        add(1, 0, 0, 1, 0, 0, ZERO,  4, 1);
        add(1, 0, 0, 1, 0, 0, ZERO,  5, 1);
        add(1, 0, 0, 1, 1, 0, RUNO,  6, 1);
        add(1, 0, 0, 0, 0, 0, RUNO,  6, 1);
        add(1, 0, 1, 1, 0, 0, START, 6, 1);
        add(1, 0, 1, 1, 0, 0, ZERO,  7, 1);
        add(1, 0, 1, 1, 1, 0, BR,    8, 1);
        add(1, 0, 0, 1, 0, 0, START, 8, 2);
        add(1, 0, 0, 1, 1, 0, RUNO,  9, 2);
        add(1, 0, 0, 0, 0, 0, RUNO,  9, 2);
        add(1, 0, 0, 0, 1, 0, RUNO,  9, 2);
        add(1, 0, 0, 0, 0, 1, RUNO,  9, 2);
        add(1, 0, 0, 0, 0, 0, RUNO,  0, 0);
        add(1, 1, 0, 0, 0, 1, HAZ,   0, 0);
        add(1, 0, 0, 0, 0, 0, RUNO,  0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].h, tbl[i].b, tbl[i].q, tbl[i].y, tbl[i].c);
            check($sformatf("vec%0d_ctl", i), {25'd0, ctl}, {25'd0, tbl[i].ctl});
            check($sformatf("vec%0d_stall", i), {24'd0, stall_cnt}, tbl[i].stall);
            check($sformatf("vec%0d_flush", i), {24'd0, flush_cnt}, tbl[i].flush);
        end

        // Access that never completes: ERROR after MEM_TIMEOUT wait cycles, only reset exits.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step(1, 0, 0, 1, 0, 0);
            check("timeout_err_low", {31'd0, mem_err}, 32'd0);
        end
        step(1, 1, 1, 1, 1, 0);
        check("timeout_err_set", {31'd0, mem_err}, 32'd1);
        check("timeout_ctl", {25'd0, ctl}, {25'd0, ZERO});
        check("timeout_stall", {24'd0, stall_cnt}, MEM_TIMEOUT + 1);
        step(1, 0, 0, 0, 1, 0);
        check("error_hold_pc_en", {31'd0, pc_en}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("recover_ctl", {25'd0, ctl}, {25'd0, RUNO});
        check("recover_err", {31'd0, mem_err}, 32'd0);
        check("recover_stall", {24'd0, stall_cnt}, 32'd0);

        // Saturation, then clear beats a same-cycle stall.
        for (int i = 0; i < CMAX + 5; i++) step(1, 1, 0, 0, 0, 0);
        check("sat_stall", {24'd0, stall_cnt}, CMAX);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check("clr_beats_inc", {24'd0, stall_cnt}, 32'd0);

        // Reset in the middle of an access returns to RUN with no pending access.
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("rst_mid_start", {31'd0, mem_start}, 32'd0);
        step(1, 0, 0, 0, 1, 0);
        check("rst_mid_ctl", {25'd0, ctl}, {25'd0, RUNO});

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
